// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Holds the program counter, drives the combinational instruction ROM and
// captures the returned word into the IF/ID register consumed by decode.
// Handles downstream stall, branch/jump redirect and a sticky illegal-PC fault.
//
// Handshake: if_valid is the valid side of the IF/ID register and "!stall" is
// decode's ready. While stall is high the register contents and if_valid hold
// unchanged; a new word is captured only on a cycle with stall low. A redirect
// is a flush: it drops if_valid regardless of stall.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] ROM_LIMIT = 32'd1020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    output logic        rom_enable,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        fault_q, fault_d;

    // Per-cycle decisions shared by the next-state and datapath logic.
    logic pc_legal;
    logic redir_legal;
    logic take_redirect;
    logic do_fetch;
    logic raise_fault;
    logic clear_fault;

    // Legality of the current PC and of a redirect target: word aligned and
    // inside the ROM. The upper bound also keeps pc+4 from ever wrapping in RUN.
    always_comb begin
        pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q <= ROM_LIMIT);
        redir_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= ROM_LIMIT);
    end

    // State register; reset forces WARMUP immediately so rom_enable drops with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one warm-up cycle, then run until an illegal PC is fetched.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARMUP: state_d = ST_RUN;
            ST_RUN: begin
                // Redirect and stall both pre-empt the legality check.
                if (!redirect_valid && !stall && !pc_legal) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (redirect_valid && redir_legal) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_WARMUP;
        endcase
    end

    // Output/decision logic: which action this cycle performs in the current state.
    always_comb begin
        take_redirect = 1'b0;
        do_fetch      = 1'b0;
        raise_fault   = 1'b0;
        clear_fault   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                end else if (stall) begin
                    // hold everything, ROM read suppressed
                end else if (!pc_legal) begin
                    raise_fault = 1'b1;
                end else begin
                    do_fetch = 1'b1;
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                    clear_fault   = redir_legal;
                end
            end
            default: begin
                // warm-up: nothing is fetched
            end
        endcase
        rom_enable = do_fetch;
    end

    // Datapath next values: PC update and IF/ID register capture/flush.
    always_comb begin
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        fault_d    = fault_q;

        if (take_redirect) begin
            // Flush: the word in IF/ID belongs to the abandoned path.
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end else if (do_fetch) begin
            pc_d       = pc_q + 32'd4;
            if_pc_d    = pc_q;
            if_instr_d = rom_data;
            if_valid_d = 1'b1;
        end else if (raise_fault) begin
            if_valid_d = 1'b0;
        end

        if (raise_fault) begin
            fault_d = 1'b1;
        end else if (clear_fault) begin
            fault_d = 1'b0;
        end

        // Nothing valid can sit in IF/ID outside RUN.
        if (state_q != ST_RUN) begin
            if_valid_d = 1'b0;
        end
    end

    // PC, IF/ID register and sticky fault flag, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            fault_q    <= fault_d;
        end
    end

    // The ROM address always follows the PC; only rom_enable gates the read.
    always_comb begin
        rom_addr    = pc_q;
        if_valid    = if_valid_q;
        if_pc       = if_pc_q;
        if_instr    = if_instr_q;
        fetch_fault = fault_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic against a
// behavioural model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] LIMIT = 32'd1020;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic        rom_enable;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // ROM image (bytes)
  logic [7:0] rom_b [0:1023];

  // model (spec-level: mode 0=warm-up, 1=running, 2=faulted)
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic        m_fault;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_enable     (rom_enable),
    .rom_data       (rom_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rb(input logic [31:0] a);
    if (a < 32'd1024) return rom_b[a[9:0]];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= LIMIT);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
    m_instr = 32'h0;
    m_fault = 1'b0;
  endtask

  // compare registered outputs against the model
  task automatic check_regs();
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("rom_addr", rom_addr, m_pc);
    if (m_valid) begin
      chk("if_pc", if_pc, m_ifpc);
      chk("if_instr", if_instr, m_instr);
    end
  endtask

  // one clock cycle: drive inputs, check the combinational ROM port,
  // advance the model, then check the registered outputs after the edge
  task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
    logic exp_en;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rom_data       = rom_word(rom_addr);
    #1;
    exp_en = (m_mode == 1) && !rv && !s && legal(m_pc);
    chk("rom_enable", {31'b0, rom_enable}, {31'b0, exp_en});
    chk("rom_addr_pre", rom_addr, m_pc);
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (rv) begin
          m_pc = rpc;
          m_valid = 1'b0;
        end else if (s) begin
        end else if (!legal(m_pc)) begin
          m_mode = 2;
          m_fault = 1'b1;
          m_valid = 1'b0;
        end else begin
          m_ifpc = m_pc;
          m_instr = rom_word(m_pc);
          m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
      default: begin
        if (rv) begin
          m_pc = rpc;
          if (legal(rpc)) begin
            m_fault = 1'b0;
            m_mode = 1;
          end
        end
      end
    endcase
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // async reset pulse from mid-cycle; outputs must clear without a clock edge
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    rom_data = rom_word(rom_addr);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_rom_enable", {31'b0, rom_enable}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_enable", {31'b0, rom_enable}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_b[i] = (i < 16) ? 8'(i) : 8'h00;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    rom_data = 32'h0;
    model_reset();
    #3;
    chk("reset_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_fault", {31'b0, fetch_fault}, 32'd0);
    chk("reset_enable", {31'b0, rom_enable}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // sequential fetch after warm-up
    step(0, 0, 0);
    chk("warmup_valid", {31'b0, if_valid}, 32'd0);
    step(0, 0, 0);
    chk("lit_pc0", if_pc, 32'd0);
    chk("lit_w0", if_instr, 32'h03020100);
    step(0, 0, 0);
    chk("lit_w4", if_instr, 32'h07060504);

    // stall holds the IF/ID register
    repeat (3) begin
      step(1, 0, 0);
      chk("stall_pc", if_pc, 32'd4);
      chk("stall_w", if_instr, 32'h07060504);
    end
    step(0, 0, 0);
    chk("after_stall_pc", if_pc, 32'd8);
    chk("after_stall_w", if_instr, 32'h0B0A0908);
    step(0, 0, 0);
    chk("lit_w12", if_instr, 32'h0F0E0D0C);
    step(0, 0, 0);
    chk("lit_pc16", if_pc, 32'd16);
    chk("lit_w16", if_instr, 32'h00000000);

    // redirect, plain and with stall
    step(0, 1, 12);
    chk("redir_flush", {31'b0, if_valid}, 32'd0);
    step(0, 0, 0);
    chk("redir_pc", if_pc, 32'd12);
    chk("redir_w", if_instr, 32'h0F0E0D0C);
    step(1, 1, 12);
    chk("redir_stall_flush", {31'b0, if_valid}, 32'd0);
    step(0, 0, 0);
    chk("redir_stall_pc", if_pc, 32'd12);

    // misaligned target faults, legal redirect recovers
    step(0, 1, 6);
    step(0, 0, 0);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    step(0, 0, 0);
    chk("mis_sticky", {31'b0, fetch_fault}, 32'd1);
    step(0, 1, 8);
    chk("mis_clear", {31'b0, fetch_fault}, 32'd0);
    step(0, 0, 0);
    chk("mis_resume_w", if_instr, 32'h0B0A0908);

    // top of ROM, then out-of-range
    step(0, 1, 1020);
    step(0, 0, 0);
    chk("limit_pc", if_pc, 32'd1020);
    step(0, 0, 0);
    chk("limit_fault", {31'b0, fetch_fault}, 32'd1);
    chk("limit_addr", rom_addr, 32'd1024);
    step(0, 1, 2000);
    chk("oor_sticky", {31'b0, fetch_fault}, 32'd1);
    step(0, 1, 0);

    // redirect beats a would-be fault
    step(0, 1, 1020);
    step(0, 0, 0);
    step(0, 1, 4);
    chk("redir_beats_fault", {31'b0, fetch_fault}, 32'd0);
    step(0, 0, 0);
    chk("redir_beats_w", if_instr, 32'h07060504);

    // async reset mid-stream, then replay the opening sequence
    chk("pre_reset_valid", {31'b0, if_valid}, 32'd1);
    async_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    chk("replay_w0", if_instr, 32'h03020100);
    step(0, 0, 0);
    chk("replay_w4", if_instr, 32'h07060504);

    // randomized traffic
    for (int i = 16; i < 1024; i++) rom_b[i] = 8'($urandom);
    for (int n = 0; n < 1500; n++) begin
      logic s;
      logic rv;
      logic [31:0] t;
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0: t = 32'($urandom_range(0, 255)) * 4;
        1: t = 32'($urandom_range(240, 255)) * 4;
        2: t = 32'($urandom_range(0, 1023)) | 32'd1;
        3: t = 32'($urandom_range(256, 4000)) * 4;
        4: t = $urandom;
        default: t = 32'($urandom_range(0, 63)) * 4;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(s, rv, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
